// File: rtl/imm_operand_seq_pkg.sv
// Shared encodings and default widths for the immediate-operand sequencer.
package imm_operand_seq_pkg;

    localparam int IMM_W_DEF  = 6;
    localparam int OPND_W_DEF = 8;
    localparam int TAG_W_DEF  = 3;
    localparam int CNT_W      = 8;

    localparam logic [1:0] OP_ZEXT    = 2'b00;
    localparam logic [1:0] OP_SEXT    = 2'b01;
    localparam logic [1:0] OP_WIDE_LO = 2'b10;
    localparam logic [1:0] OP_WIDE_HI = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WAIT_HI = 1'b1
    } state_e;

endpackage

// File: rtl/imm_operand_seq_if.sv
// Request, extension-unit and operand-slot signals of the sequencer.
interface imm_operand_seq_if
    import imm_operand_seq_pkg::*;
#(
    parameter int IMMEDIATE_WIDTH   = IMM_W_DEF,
    parameter int ALU_OPERAND_WIDTH = OPND_W_DEF,
    parameter int TAG_WIDTH         = TAG_W_DEF
) ();
    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [1:0]                   in_op;
    logic [IMMEDIATE_WIDTH-1:0]   in_imm;
    logic [TAG_WIDTH-1:0]         in_tag;
    logic [IMMEDIATE_WIDTH-1:0]   ext_imm;
    logic                         ext_cs;
    logic [ALU_OPERAND_WIDTH-1:0] ext_result;
    logic                         out_valid;
    logic                         out_ready;
    logic [ALU_OPERAND_WIDTH-1:0] out_operand;
    logic [TAG_WIDTH-1:0]         out_tag;
    logic                         err;
    logic [CNT_W-1:0]             issue_count;

    modport slave (
        input  flush, in_valid, in_op, in_imm, in_tag, ext_result, out_ready,
        output in_ready, ext_imm, ext_cs, out_valid, out_operand, out_tag, err, issue_count
    );

    modport master (
        output flush, in_valid, in_op, in_imm, in_tag, ext_result, out_ready,
        input  in_ready, ext_imm, ext_cs, out_valid, out_operand, out_tag, err, issue_count
    );
endinterface

// File: rtl/imm_operand_seq_operand_slot.sv
// One-entry valid/ready holding register for a finished operand and its tag.
module imm_operand_seq_operand_slot #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic              pop,
    input  logic [DATA_W-1:0] load_data,
    input  logic [TAG_W-1:0]  load_tag,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [TAG_W-1:0]  tag
);
    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic [TAG_W-1:0]  tag_r;

    // Slot occupancy and payload; a load in the pop cycle keeps the slot full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
            tag_r   <= {TAG_W{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            tag_r   <= load_tag;
        end else if (pop) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign tag   = tag_r;
endmodule

// File: rtl/imm_operand_seq.sv
// Immediate-operand sequencer: extends single immediates, pairs WIDE_LO/WIDE_HI beats.
module imm_operand_seq
    import imm_operand_seq_pkg::*;
#(
    parameter int IMMEDIATE_WIDTH   = IMM_W_DEF,
    parameter int ALU_OPERAND_WIDTH = OPND_W_DEF,
    parameter int TAG_WIDTH         = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    imm_operand_seq_if.slave  bus
);
    localparam int HI_W = ALU_OPERAND_WIDTH - IMMEDIATE_WIDTH;

    state_e                       state_r;
    state_e                       next_state_s;
    logic [IMMEDIATE_WIDTH-1:0]   lo_r;
    logic [TAG_WIDTH-1:0]         lo_tag_r;
    logic                         err_r;
    logic [CNT_W-1:0]             issue_count_r;
    logic                         in_ready_s;
    logic                         accept_s;
    logic                         pop_s;
    logic                         out_valid_s;
    logic                         load_s;
    logic [ALU_OPERAND_WIDTH-1:0] load_data_s;
    logic [TAG_WIDTH-1:0]         load_tag_s;
    logic                         lo_wr_s;
    logic                         err_set_s;

    // Flush blocks acceptance and wins over a simultaneous out handshake.
    assign in_ready_s = !bus.flush & (!out_valid_s | bus.out_ready);
    assign accept_s   = bus.in_valid & in_ready_s;
    assign pop_s      = out_valid_s & bus.out_ready & !bus.flush;

    assign bus.in_ready    = in_ready_s;
    assign bus.ext_imm     = bus.in_imm;
    assign bus.ext_cs      = (bus.in_op == OP_SEXT);
    assign bus.err         = err_r;
    assign bus.issue_count = issue_count_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else if (bus.flush) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: any accepted WIDE_LO (re)arms the pairing, everything else returns to IDLE.
    always_comb begin
        next_state_s = state_r;
        if (accept_s) begin
            case (state_r)
                ST_IDLE:    next_state_s = (bus.in_op == OP_WIDE_LO) ? ST_WAIT_HI : ST_IDLE;
                ST_WAIT_HI: next_state_s = (bus.in_op == OP_WIDE_LO) ? ST_WAIT_HI : ST_IDLE;
                default:    next_state_s = ST_IDLE;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Per-accept actions: slot load, low-half capture and protocol-error detection.
    always_comb begin
        load_s      = 1'b0;
        load_data_s = bus.ext_result;
        load_tag_s  = bus.in_tag;
        lo_wr_s     = 1'b0;
        err_set_s   = 1'b0;
        if (accept_s) begin
            case (bus.in_op)
                OP_ZEXT, OP_SEXT: begin
                    load_s    = 1'b1;
                    err_set_s = (state_r == ST_WAIT_HI);
                end
                OP_WIDE_LO: begin
                    lo_wr_s   = 1'b1;
                    err_set_s = (state_r == ST_WAIT_HI);
                end
                OP_WIDE_HI: begin
                    if (state_r == ST_WAIT_HI) begin
                        load_s      = 1'b1;
                        load_data_s = {bus.in_imm[HI_W-1:0], lo_r};
                        load_tag_s  = lo_tag_r;
                    end else begin
                        err_set_s = 1'b1;
                    end
                end
                default: begin
                    err_set_s = 1'b1;
                end
            endcase
        end else begin
            load_s = 1'b0;
        end
    end

    // Pending low half of a wide constant.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            lo_r     <= {IMMEDIATE_WIDTH{1'b0}};
            lo_tag_r <= {TAG_WIDTH{1'b0}};
        end else if (lo_wr_s) begin
            lo_r     <= bus.in_imm;
            lo_tag_r <= bus.in_tag;
        end else begin
            lo_r     <= lo_r;
            lo_tag_r <= lo_tag_r;
        end
    end

    // Error pulse and delivered-operand counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r         <= 1'b0;
            issue_count_r <= 8'd0;
        end else begin
            err_r         <= err_set_s;
            issue_count_r <= pop_s ? issue_count_r + 8'd1 : issue_count_r;
        end
    end

    imm_operand_seq_operand_slot #(
        .DATA_W (ALU_OPERAND_WIDTH),
        .TAG_W  (TAG_WIDTH)
    ) u_operand_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .load      (load_s),
        .pop       (pop_s),
        .load_data (load_data_s),
        .load_tag  (load_tag_s),
        .valid     (out_valid_s),
        .data      (bus.out_operand),
        .tag       (bus.out_tag)
    );

    assign bus.out_valid = out_valid_s;
endmodule

// File: tb/tb_imm_operand_seq.sv
// Randomized bench for imm_operand_seq against an arithmetic reference model.
module tb_imm_operand_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_operand_seq_if bus ();

    imm_operand_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External constant-extension unit.
    assign bus.ext_result = bus.ext_cs ? {{2{bus.ext_imm[5]}}, bus.ext_imm} : {2'b00, bus.ext_imm};

    int n_tests = 0;
    int n_fail  = 0;

    bit m_started = 1'b0;
    bit m_valid   = 1'b0;
    int m_operand = 0;
    int m_tag     = 0;
    bit m_err     = 1'b0;
    int m_count   = 0;
    bit m_pend    = 1'b0;
    int m_lo      = 0;
    int m_lo_tag  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return !bus.flush && (!m_valid || bus.out_ready);
    endfunction

    // Advance the model by one clock edge from the inputs still held on the bus.
    task automatic model_step();
        int imm;
        int tag;
        bit acc;
        bit pop;
        bit e;
        if (!rst_n) begin
            m_started = 1'b1;
            m_valid = 1'b0; m_operand = 0; m_tag = 0; m_err = 1'b0;
            m_count = 0; m_pend = 1'b0; m_lo = 0;
        end else begin
            imm = int'(bus.in_imm);
            tag = int'(bus.in_tag);
            acc = bus.in_valid && model_ready();
            pop = m_valid && bus.out_ready && !bus.flush;
            e   = 1'b0;
            if (bus.flush) begin
                m_valid = 1'b0;
                m_pend  = 1'b0;
                m_lo    = 0;
            end else begin
                if (pop) begin
                    m_count = (m_count + 1) % 256;
                    m_valid = 1'b0;
                end
                if (acc) begin
                    case (int'(bus.in_op))
                        0: begin
                            e = m_pend; m_pend = 1'b0;
                            m_valid = 1'b1; m_operand = imm; m_tag = tag;
                        end
                        1: begin
                            e = m_pend; m_pend = 1'b0;
                            m_valid = 1'b1; m_operand = (imm >= 32) ? imm + 192 : imm; m_tag = tag;
                        end
                        2: begin
                            e = m_pend; m_pend = 1'b1; m_lo = imm; m_lo_tag = tag;
                        end
                        default: begin
                            if (m_pend) begin
                                m_valid = 1'b1; m_operand = (imm % 4) * 64 + m_lo;
                                m_tag = m_lo_tag; m_pend = 1'b0;
                            end else begin
                                e = 1'b1;
                            end
                        end
                    endcase
                end
            end
            m_err = e;
        end
    endtask

    // Drive one cycle of stimulus, check the combinational outputs, step the model.
    task automatic cyc(input bit v, input logic [1:0] op, input logic [5:0] imm,
                       input logic [2:0] tag, input bit ordy, input bit fl, input bit rn);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_imm    = imm;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        bus.flush     = fl;
        rst_n         = rn;
        #1;
        if (m_started) begin
            chk("in_ready", bus.in_ready, model_ready());
            chk("ext_cs", bus.ext_cs, (op == 2'b01));
            chk("ext_imm", bus.ext_imm, imm);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Registered outputs against the model once per cycle.
    always @(negedge clk) begin
        if (m_started) begin
            chk("out_valid", bus.out_valid, m_valid);
            chk("out_operand", bus.out_operand, m_operand);
            chk("out_tag", bus.out_tag, m_tag);
            chk("err", bus.err, m_err);
            chk("issue_count", bus.issue_count, m_count);
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_imm = 6'd0; bus.in_tag = 3'd0;
        bus.out_ready = 1'b1; bus.flush = 1'b0;
        @(negedge clk);
        cyc(1'b0, 2'b00, 6'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 6'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_operand", bus.out_operand, 8'h00);
        chk("rst_count", bus.issue_count, 8'd0);
        chk("rst_err", bus.err, 1'b0);

        cyc(1'b1, 2'b00, 6'h25, 3'd1, 1'b1, 1'b0, 1'b1);
        chk("zext_valid", bus.out_valid, 1'b1);
        chk("zext_operand", bus.out_operand, 8'h25);
        cyc(1'b1, 2'b01, 6'h25, 3'd2, 1'b1, 1'b0, 1'b1);
        chk("sext_operand", bus.out_operand, 8'hE5);
        chk("sext_count", bus.issue_count, 8'd1);

        cyc(1'b1, 2'b10, 6'h3F, 3'd5, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 6'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 2'b11, 6'b000010, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("wide_operand", bus.out_operand, 8'hBF);
        chk("wide_tag", bus.out_tag, 3'd5);
        chk("wide_err", bus.err, 1'b0);

        cyc(1'b1, 2'b00, 6'h01, 3'd1, 1'b0, 1'b0, 1'b1);
        chk("held_operand", bus.out_operand, 8'hBF);
        cyc(1'b1, 2'b01, 6'h3E, 3'd6, 1'b1, 1'b0, 1'b1);
        chk("b2b_operand", bus.out_operand, 8'hFE);
        cyc(1'b0, 2'b00, 6'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("b2b_count", bus.issue_count, 8'd4);

        cyc(1'b1, 2'b11, 6'h15, 3'd1, 1'b1, 1'b0, 1'b1);
        chk("hi_idle_err", bus.err, 1'b1);
        chk("hi_idle_valid", bus.out_valid, 1'b0);
        cyc(1'b1, 2'b10, 6'h0A, 3'd2, 1'b1, 1'b0, 1'b1);
        chk("err_one_cycle", bus.err, 1'b0);
        cyc(1'b1, 2'b00, 6'h07, 3'd3, 1'b1, 1'b0, 1'b1);
        chk("lo_zext_err", bus.err, 1'b1);
        chk("lo_zext_operand", bus.out_operand, 8'h07);
        cyc(1'b1, 2'b11, 6'h01, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("back_idle_err", bus.err, 1'b1);

        cyc(1'b1, 2'b00, 6'h11, 3'd1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 2'b00, 6'h12, 3'd1, 1'b1, 1'b1, 1'b1);
        chk("flush_valid", bus.out_valid, 1'b0);
        chk("flush_err", bus.err, 1'b0);
        cyc(1'b1, 2'b10, 6'h22, 3'd4, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 2'b00, 6'h00, 3'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 2'b11, 6'h01, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("flush_hi_err", bus.err, 1'b1);

        cyc(1'b0, 2'b00, 6'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) cyc(1'b1, 2'b00, 6'(i), 3'(i), 1'b1, 1'b0, 1'b1);
        chk("count_255", bus.issue_count, 8'd255);
        cyc(1'b0, 2'b00, 6'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("count_wrap", bus.issue_count, 8'd0);

        cyc(1'b1, 2'b00, 6'h09, 3'd7, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 2'b10, 6'h3F, 3'd5, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 2'b00, 6'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_valid", bus.out_valid, 1'b0);
        chk("rst_mid_operand", bus.out_operand, 8'h00);
        chk("rst_mid_tag", bus.out_tag, 3'd0);
        chk("rst_mid_err", bus.err, 1'b0);
        cyc(1'b1, 2'b11, 6'h03, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("rst_mid_hi_err", bus.err, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(9) < 7), 2'($urandom_range(3)), 6'($urandom_range(63)),
                3'($urandom_range(7)), ($urandom_range(3) != 0),
                ($urandom_range(19) == 0), ($urandom_range(199) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_operand_seq.md
# imm_operand_seq

- Immediate-operand sequencer in the decode→execute path.
- Accepts decoded immediate requests over a valid/ready handshake and selects zero- or sign-extension on the external constant-extension unit.
- Assembles full-width 8-bit constants from two consecutive 6-bit immediate beats.
- Presents each finished ALU operand, with its destination tag, in a one-entry output slot held until execute accepts it.

## Interface
Parameters:
- IMMEDIATE_WIDTH, 6, width of instruction immediate field
- ALU_OPERAND_WIDTH, 8, width of produced operand
- TAG_WIDTH, 3, destination-register tag width

Ports (clk single clock; rst_n synchronous, active-low, sampled on rising clk):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  pipeline flush, synchronous
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid & in_ready
- in_op  in  2  00 ZEXT, 01 SEXT, 10 WIDE_LO, 11 WIDE_HI
- in_imm  in  IMMEDIATE_WIDTH  immediate field
- in_tag  in  TAG_WIDTH  destination tag
- ext_imm  out  IMMEDIATE_WIDTH  to extension unit; equals in_imm (combinational)
- ext_cs  out  1  to extension unit; 1 only when in_op==SEXT, else 0
- ext_result  in  ALU_OPERAND_WIDTH  extended value from unit, combinational same cycle
- out_valid  out  1  operand slot full
- out_ready  in  1  execute consumes when out_valid & out_ready
- out_operand  out  ALU_OPERAND_WIDTH  operand
- out_tag  out  TAG_WIDTH  tag
- err  out  1  one-cycle protocol-error pulse
- issue_count  out  8  operands delivered (out handshakes), wraps 255→0

## Operation
- States: IDLE, WAIT_HI.
- in_ready = !flush & (!out_valid | out_ready).
- In IDLE, on accept:
  - ZEXT/SEXT: slot ← ext_result, in_tag.
  - WIDE_LO: lo_reg ← in_imm, lo_tag ← in_tag; go to WAIT_HI; slot unchanged.
  - WIDE_HI: discarded; err pulses; stay in IDLE.
- In WAIT_HI, on accept:
  - WIDE_HI: slot ← {in_imm[1:0], lo_reg}, tag ← lo_tag; in_imm[5:2] ignored; in_tag ignored; return to IDLE.
  - ZEXT/SEXT: err pulses; pending low half dropped; request processed as in IDLE; go to IDLE.
  - WIDE_LO: err pulses; lo_reg/lo_tag overwritten; stay in WAIT_HI.
- Slot: accept writing the slot and an out handshake in the same cycle → new value loaded, out_valid stays 1. Out handshake alone → out_valid 0.
- flush: out_valid←0, state←IDLE, lo_reg cleared, no err; issue_count kept; flush overrides a simultaneous out handshake (not counted).

## Timing
- Reset values: out_valid 0, out_operand 0, out_tag 0, err 0, issue_count 0, state IDLE; in_ready 1 the cycle after reset deasserts.
- ZEXT/SEXT latency: out_valid 1 cycle after the accept edge.
- WIDE: out_valid 1 cycle after the WIDE_HI accept; no bound on the gap between beats.
- err: asserted for exactly the cycle after the offending accept.
- Full throughput: one operand per cycle while out_ready=1.
- rst_n low mid-WIDE pair: pending half lost, no err.

## Structure
- Package imm_operand_seq_pkg: in_op encoding constants, state enum, default widths.
- Sub-module operand_slot: one-entry valid/ready register (data+tag, load, pop, flush). FSM, lo_reg and counter stay in top.

## Test plan
- Reset, then ZEXT imm=6'h25 with ext_result=8'h25 → next cycle out_valid=1, out_operand=8'h25; SEXT imm=6'h25, ext_result=8'hE5 → 8'hE5, ext_cs=1 during the accept.
- WIDE_LO imm=6'h3F tag=5, idle 3 cycles, WIDE_HI imm=6'b000010 → out_operand=8'hBF, out_tag=5, err never set.
- out_ready=0 with slot full → in_ready=0, request held; release out_ready with a new SEXT → back-to-back delivery, issue_count +2.
- WIDE_HI in IDLE → err pulse, no output. WIDE_LO then ZEXT → err pulse; ZEXT value delivered; state IDLE.
- flush while out_valid=1 and in WAIT_HI → out_valid 0 next cycle, subsequent WIDE_HI flags err.
- 256 deliveries → issue_count wraps to 0; rst_n low mid-pair → all outputs at reset values.
